// File: rtl/dds_update_scheduler_if.sv
// Control/status bundle between the host-side controller and the io_update scheduler.
interface dds_update_scheduler_if #(
  parameter int WIDTH = 16
);
  logic             cfg_ready;
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] burst_len;
  logic             alt_en;
  logic             sweep_dir;
  logic             io_update;
  logic             sweep_sel;
  logic             busy;
  logic [WIDTH-1:0] shot_cnt;
  logic             burst_done;
  logic             start_err;

  modport master (
    output cfg_ready, start, stop, burst_len, alt_en, sweep_dir,
    input  io_update, sweep_sel, busy, shot_cnt, burst_done, start_err
  );

  modport slave (
    input  cfg_ready, start, stop, burst_len, alt_en, sweep_dir,
    output io_update, sweep_sel, busy, shot_cnt, burst_done, start_err
  );
endinterface

// File: rtl/dds_update_scheduler.sv
// Periodic io_update / sweep_sel trigger generator feeding dds_time_control,
// gated by AD9910 configuration status, with burst, continuous and stop control.
module dds_update_scheduler #(
  parameter int FRE        = 10000,
  parameter int CLKNUM     = 2,
  parameter int PERIOD_CNT = 1_000_000_000 / FRE / CLKNUM,
  parameter int UPD_WIDTH  = 8,
  parameter int WIDTH      = 16
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  dds_update_scheduler_if.slave bus
);

  if (longint'(PERIOD_CNT - 1) >= (longint'(1) << WIDTH)) begin : g_bad_period
    $error("dds_update_scheduler: PERIOD_CNT-1 does not fit in WIDTH bits");
  end
  if (UPD_WIDTH < 1 || UPD_WIDTH >= PERIOD_CNT) begin : g_bad_upd
    $error("dds_update_scheduler: UPD_WIDTH must satisfy 1 <= UPD_WIDTH < PERIOD_CNT");
  end

  localparam logic [WIDTH-1:0] LAST_CNT = WIDTH'(PERIOD_CNT - 1);
  localparam logic [WIDTH-1:0] UPD_LAST = WIDTH'(UPD_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    WAIT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shot_q, shot_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic             sw_q, sw_d;
  logic             io_q, io_d;
  logic             stop_pend_q, stop_pend_d;
  logic             err_q, err_d;
  logic             done_now;
  logic             end_req;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shot_q      <= '0;
      len_q       <= '0;
      sw_q        <= 1'b0;
      io_q        <= 1'b0;
      stop_pend_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shot_q      <= shot_d;
      len_q       <= len_d;
      sw_q        <= sw_d;
      io_q        <= io_d;
      stop_pend_q <= stop_pend_d;
      err_q       <= err_d;
    end
  end

  // Live stop and cfg_ready loss are folded in so a request on the final WAIT
  // cycle still ends the burst at that boundary.
  assign end_req = stop_pend_q | bus.stop | ~bus.cfg_ready |
                   ((len_q != '0) && (shot_q == len_q));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shot_d      = shot_q;
    len_d       = len_q;
    sw_d        = sw_q;
    io_d        = io_q;
    stop_pend_d = stop_pend_q;
    err_d       = 1'b0;
    done_now    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.cfg_ready) begin
            state_d = PULSE;
            cnt_d   = '0;
            len_d   = bus.burst_len;
            shot_d  = WIDTH'(1);
            sw_d    = bus.alt_en ? 1'b0 : bus.sweep_dir;
            io_d    = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      PULSE: begin
        stop_pend_d = stop_pend_q | bus.stop | ~bus.cfg_ready;
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == UPD_LAST) begin
          state_d = WAIT;
          io_d    = 1'b0;
        end
      end
      WAIT: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (end_req) begin
            state_d     = IDLE;
            stop_pend_d = 1'b0;
            done_now    = 1'b1;
          end else begin
            state_d = PULSE;
            io_d    = 1'b1;
            shot_d  = (shot_q == '1) ? shot_q : shot_q + 1'b1;
            sw_d    = bus.alt_en ? ~sw_q : bus.sweep_dir;
          end
        end else begin
          stop_pend_d = stop_pend_q | bus.stop | ~bus.cfg_ready;
          cnt_d       = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.io_update  = io_q;
  assign bus.sweep_sel  = sw_q;
  assign bus.shot_cnt   = shot_q;
  assign bus.start_err  = err_q;
  assign bus.burst_done = done_now;
  assign bus.busy       = (state_q != IDLE) && !done_now;

endmodule
